cmd_issuer: RTL



---
 rtl/fusion_pkg.sv | 26 ++
 rtl/cmd_issuer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fusion_pkg.sv
// Shared accelerator definitions: opcode encodings, command packet field positions, default magic.
package fusion_pkg;

    localparam logic [2:0] OP_IDLE   = 3'b000;
    localparam logic [2:0] OP_CONV1  = 3'b001;
    localparam logic [2:0] OP_CONV3  = 3'b010;
    localparam logic [2:0] OP_POOL3  = 3'b011;
    localparam logic [2:0] OP_POOL13 = 3'b100;

    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 24;
    localparam int LEN_HI   = 23;
    localparam int LEN_LO   = 8;
    localparam int RSVD_HI  = 7;
    localparam int RSVD_LO  = 3;
    localparam int OPC_HI   = 2;
    localparam int OPC_LO   = 0;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hC5;

    // Opcodes above POOL13 are reserved and must be rejected.
    function automatic logic op_known(input logic [2:0] op);
        return op <= OP_POOL13;
    endfunction

endpackage

// File: rtl/cmd_issuer.sv
// Pops 3-word command packets, validates/decodes them and issues one op at a time; word0 pop to op_issue is 7 cycles.
// An empty FIFO stalls FETCH with fifo_rd_en low; no new packet is fetched until op_done or watchdog expiry.
module cmd_issuer
    import fusion_pkg::*;
#(
    parameter logic [7:0] MAGIC = DEFAULT_MAGIC,
    parameter int         TO_W  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [2:0]  op_type,
    output logic        op_issue,
    output logic [15:0] cmd_len,
    output logic [31:0] cmd_src,
    output logic [31:0] cmd_dst,
    input  logic        op_done,
    output logic        busy,
    output logic        err_cmd,
    output logic        err_to,
    input  logic        err_clr,
    output logic [15:0] cmd_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_DECODE, S_ISSUE, S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0][31:0]  words_q, words_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [2:0]        op_type_q, op_type_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_cmd_q, err_to_q;
    logic              set_err_cmd, set_err_to;
    logic              unused_rsvd;

    assign unused_rsvd = ^words_q[0][RSVD_HI:RSVD_LO];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        words_d     = words_q;
        wd_d        = wd_q;
        op_type_d   = op_type_q;
        len_d       = len_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        set_err_cmd = 1'b0;
        set_err_to  = 1'b0;
        fifo_rd_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    idx_d   = 2'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_d = S_CAPT;
            end
            S_CAPT: begin
                // Non-FWFT FIFO: data popped last cycle is valid now.
                case (idx_q)
                    2'd0:    words_d[0] = fifo_dout;
                    2'd1:    words_d[1] = fifo_dout;
                    default: words_d[2] = fifo_dout;
                endcase
                if (idx_q == 2'd2) begin
                    state_d = S_DECODE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (words_q[0][MAGIC_HI:MAGIC_LO] != MAGIC ||
                    !op_known(words_q[0][OPC_HI:OPC_LO])) begin
                    set_err_cmd = 1'b1;
                    state_d     = S_IDLE;
                end else if (words_q[0][OPC_HI:OPC_LO] == OP_IDLE) begin
                    state_d = S_IDLE;
                end else begin
                    op_type_d = words_q[0][OPC_HI:OPC_LO];
                    len_d     = words_q[0][LEN_HI:LEN_LO];
                    src_d     = words_q[1];
                    dst_d     = words_q[2];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q + 16'd1;
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturated watchdog means expiry; it never wraps back to zero.
                if (op_done) begin
                    state_d = S_IDLE;
                end else if (&wd_q) begin
                    set_err_to = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wd_d = wd_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            words_q   <= '0;
            wd_q      <= '0;
            op_type_q <= OP_IDLE;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            err_cmd_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            wd_q      <= wd_d;
            op_type_q <= op_type_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            // A new error in the same cycle as err_clr stays set.
            err_cmd_q <= set_err_cmd | (err_cmd_q & ~err_clr);
            err_to_q  <= set_err_to  | (err_to_q  & ~err_clr);
        end
    end

    assign op_issue = (state_q == S_ISSUE);
    assign busy     = (state_q != S_IDLE);
    assign op_type  = op_type_q;
    assign cmd_len  = len_q;
    assign cmd_src  = src_q;
    assign cmd_dst  = dst_q;
    assign cmd_cnt  = cnt_q;
    assign err_cmd  = err_cmd_q;
    assign err_to   = err_to_q;

endmodule
